// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble), one adjust+shift step per clock.
// Returns registered BCD digits, a leading-zero mask and a sticky overflow flag.
module bcd_seq_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      number,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_bin_sr, w_bin_nxt;
    logic [BCD_W-1:0]   r_digit_sr, w_digit_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [DIGITS-1:0]  r_dv, w_dv_nxt;
    logic               r_overflow, w_overflow_nxt;
    logic               r_done, w_done_nxt;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shift_digits;
    logic               w_ovf_step;
    logic               w_last;
    logic [DIGITS-1:0]  w_mask;

    // Add 3 to every digit >= 5; digits are independent 4-bit adds.
    function automatic logic [BCD_W-1:0] adjust(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (d[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = d[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Bit k set when digit k or any higher digit is nonzero; ones digit always shown.
    function automatic logic [DIGITS-1:0] lead_mask(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              any;
        m   = '0;
        any = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            any  = any | (d[4*k +: 4] != 4'd0);
            m[k] = any;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    assign w_adj          = adjust(r_digit_sr);
    assign w_shift_digits = {w_adj[BCD_W-2:0], r_bin_sr[WIDTH-1]};
    assign w_ovf_step     = r_ovf | w_adj[BCD_W-1];
    assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_mask         = lead_mask(w_shift_digits);

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin_sr;
        w_digit_nxt    = r_digit_sr;
        w_cnt_nxt      = r_cnt;
        w_ovf_nxt      = r_ovf;
        w_bcd_nxt      = r_bcd;
        w_dv_nxt       = r_dv;
        w_overflow_nxt = r_overflow;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_bin_nxt   = number;
                    w_digit_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            S_SHIFT: begin
                w_bin_nxt   = r_bin_sr << 1;
                w_digit_nxt = w_shift_digits;
                w_ovf_nxt   = w_ovf_step;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (w_last) begin
                    // Publish only the finished result so outputs never show partial values.
                    w_state_nxt    = S_DONE;
                    w_bcd_nxt      = w_shift_digits;
                    w_dv_nxt       = w_mask;
                    w_overflow_nxt = w_ovf_step;
                    w_done_nxt     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bin_sr   <= '0;
            r_digit_sr <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_dv       <= DIGITS'(1);
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bin_sr   <= w_bin_nxt;
            r_digit_sr <= w_digit_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_bcd      <= w_bcd_nxt;
            r_dv       <= w_dv_nxt;
            r_overflow <= w_overflow_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign digit_valid = r_dv;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed and model-checked bench for bcd_seq_converter in three configurations
// (16b/5 digits, 8b/3 digits, 8b/2 digits with overflow).
module tb_bcd_seq_converter;

    logic        clk;
    logic        reset;

    logic        start16;
    logic [15:0] num16;
    logic        ready16, busy16, done16, ovf16;
    logic [19:0] bcd16;
    logic [4:0]  dv16;

    logic        start8;
    logic [7:0]  num8;
    logic        ready8a, busy8a, done8a, ovf8a;
    logic [11:0] bcd8a;
    logic [2:0]  dv8a;
    logic        ready8b, busy8b, done8b, ovf8b;
    logic [7:0]  bcd8b;
    logic [1:0]  dv8b;

    int checks = 0;
    int errors = 0;

    bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .number(num16),
        .ready(ready16), .busy(busy16), .done(done16),
        .bcd(bcd16), .digit_valid(dv16), .overflow(ovf16)
    );

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_dut8a (
        .clk(clk), .reset(reset), .start(start8), .number(num8),
        .ready(ready8a), .busy(busy8a), .done(done8a),
        .bcd(bcd8a), .digit_valid(dv8a), .overflow(ovf8a)
    );

    bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_dut8b (
        .clk(clk), .reset(reset), .start(start8), .number(num8),
        .ready(ready8b), .busy(busy8b), .done(done8b),
        .bcd(bcd8b), .digit_valid(dv8b), .overflow(ovf8b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_dv(input int unsigned v);
        logic [4:0] m;
        int unsigned p;
        m = 5'd1;
        p = 10;
        for (int k = 1; k < 5; k++) begin
            m[k] = (v >= p);
            p = p * 10;
        end
        return m;
    endfunction

    function automatic logic [15:0] held_val(input int k);
        return 16'(k * 2731 + 13);
    endfunction

    // One conversion on the 16-bit unit; lat = negedges from start release to done (0 = timeout).
    task automatic run16(input logic [15:0] n, output int lat);
        @(negedge clk);
        start16 = 1'b1;
        num16   = n;
        @(negedge clk);
        start16 = 1'b0;
        num16   = 16'($urandom);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Same operand to both 8-bit units, which run in lockstep.
    task automatic run8(input logic [7:0] n, output int lat);
        @(negedge clk);
        start8 = 1'b1;
        num8   = n;
        @(negedge clk);
        start8 = 1'b0;
        num8   = 8'($urandom);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (done8a === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int dcount;
        int seen;
        logic [15:0] rv;

        reset   = 1'b1;
        start16 = 1'b0;
        num16   = '0;
        start8  = 1'b0;
        num8    = '0;

        #2;
        chk("rst_bcd16", 32'(bcd16), 32'h0);
        chk("rst_dv16", 32'(dv16), 32'h1);
        chk("rst_ovf16", 32'(ovf16), 32'h0);
        chk("rst_done16", 32'(done16), 32'h0);
        chk("rst_ready16", 32'(ready16), 32'h1);
        chk("rst_busy16", 32'(busy16), 32'h0);
        chk("rst_dv8b", 32'(dv8b), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        run16(16'd65535, lat);
        chk("lat16", 32'(lat), 32'd16);
        chk("bcd_65535", 32'(bcd16), 32'h65535);
        chk("dv_65535", 32'(dv16), 32'h1f);
        chk("ovf_65535", 32'(ovf16), 32'h0);
        chk("busy_in_done", 32'(busy16), 32'h1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done16), 32'h0);
        chk("ready_after_done", 32'(ready16), 32'h1);
        chk("bcd_hold", 32'(bcd16), 32'h65535);

        run16(16'd0, lat);
        chk("bcd_0", 32'(bcd16), 32'h0);
        chk("dv_0", 32'(dv16), 32'h01);
        chk("ovf_0", 32'(ovf16), 32'h0);

        run16(16'd409, lat);
        chk("bcd_409", 32'(bcd16), 32'h00409);
        chk("dv_409", 32'(dv16), 32'h07);

        run8(8'd255, lat);
        chk("lat8", 32'(lat), 32'd8);
        chk("d3_bcd_255", 32'(bcd8a), 32'h255);
        chk("d3_dv_255", 32'(dv8a), 32'h7);
        chk("d3_ovf_255", 32'(ovf8a), 32'h0);
        chk("d2_done_255", 32'(done8b), 32'h1);
        chk("d2_bcd_255", 32'(bcd8b), 32'h55);
        chk("d2_dv_255", 32'(dv8b), 32'h3);
        chk("d2_ovf_255", 32'(ovf8b), 32'h1);

        run8(8'd99, lat);
        chk("d3_bcd_99", 32'(bcd8a), 32'h099);
        chk("d3_dv_99", 32'(dv8a), 32'h3);
        chk("d2_bcd_99", 32'(bcd8b), 32'h99);
        chk("d2_ovf_99", 32'(ovf8b), 32'h0);

        run8(8'd100, lat);
        chk("d3_bcd_100", 32'(bcd8a), 32'h100);
        chk("d3_ovf_100", 32'(ovf8a), 32'h0);
        chk("d2_bcd_100", 32'(bcd8b), 32'h00);
        chk("d2_dv_100", 32'(dv8b), 32'h1);
        chk("d2_ovf_100", 32'(ovf8b), 32'h1);

        // start held high with number changing: accepts at negedge-indexed cycles 0, 18, 36.
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 9 || k == 17 || k == 35) chk("held_ready_low", 32'(ready16), 32'h0);
            if (k == 18) chk("held_ready_high", 32'(ready16), 32'h1);
            if (done16 === 1'b1) begin
                dcount++;
                chk("held_done_slot", 32'((k - 17) % 18), 32'd0);
                chk("held_bcd", 32'(bcd16), 32'(ref_bcd(32'(held_val(k - 17)))));
            end
            start16 = (k < 40);
            num16   = held_val(k);
        end
        chk("held_done_count", 32'(dcount), 32'd3);

        for (int i = 0; i < 300; i++) begin
            rv = 16'($urandom);
            run16(rv, lat);
            chk("rnd_bcd", 32'(bcd16), 32'(ref_bcd(32'(rv))));
            chk("rnd_dv", 32'(dv16), 32'(ref_dv(32'(rv))));
            chk("rnd_ovf", 32'(ovf16), 32'h0);
        end

        run16(16'd9999, lat);
        chk("bcd_9999", 32'(bcd16), 32'h09999);

        // Abort a conversion with a mid-cycle reset.
        @(negedge clk);
        start16 = 1'b1;
        num16   = 16'd777;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_bcd", 32'(bcd16), 32'h0);
        chk("abort_dv", 32'(dv16), 32'h1);
        chk("abort_ovf", 32'(ovf16), 32'h0);
        chk("abort_ready", 32'(ready16), 32'h1);
        chk("abort_busy", 32'(busy16), 32'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) reset = 1'b0;
            if (done16 === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run16(16'd1234, lat);
        chk("lat_after_abort", 32'(lat), 32'd16);
        chk("bcd_1234", 32'(bcd16), 32'h01234);
        chk("dv_1234", 32'(dv16), 32'h0f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
